// File: rtl/fifo_2c_push_sched_pkg.sv
// Shared types and widths for the dual-clock FIFO push scheduler.
package fifo_2c_push_sched_pkg;

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StClrAssert = 2'd1,
    StClrWait   = 2'd2,
    StClrDone   = 2'd3
  } state_e;

  localparam int unsigned STALL_CNT_W = 16;
  // Wide enough for BURST_MAX up to 15.
  localparam int unsigned BURST_CNT_W = 4;

endpackage

// File: rtl/rr_arb_burst.sv
// Round-robin arbiter with a per-holder burst limit; one-hot grant plus index.
module rr_arb_burst
  import fifo_2c_push_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned REQ_ID_W  = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [NUM_REQ-1:0]  req_valid_i,
  output logic                gnt_valid_o,
  output logic [NUM_REQ-1:0]  gnt_onehot_o,
  output logic [REQ_ID_W-1:0] gnt_idx_o
);

  logic [REQ_ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [REQ_ID_W-1:0]    holder_q, holder_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [BURST_CNT_W-1:0] cnt_next;
  logic                   holder_active, keep, found;
  logic [REQ_ID_W-1:0]    start, pick, idx;
  logic [REQ_ID_W:0]      sum;

  function automatic logic [REQ_ID_W-1:0] wrap_inc(input logic [REQ_ID_W-1:0] v);
    if (v == REQ_ID_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return v + REQ_ID_W'(1);
  endfunction

  // A zero burst count means nobody holds the grant; the scan then starts at rr_ptr.
  always_comb begin
    holder_active = (burst_cnt_q != '0);
    keep          = holder_active && req_valid_i[holder_q];
    start         = holder_active ? wrap_inc(holder_q) : rr_ptr_q;
    found         = 1'b0;
    pick          = '0;
    sum           = '0;
    idx           = '0;
    if (keep) begin
      found = 1'b1;
      pick  = holder_q;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        sum = {1'b0, start} + (REQ_ID_W + 1)'(i);
        if (sum >= (REQ_ID_W + 1)'(NUM_REQ)) begin
          sum = sum - (REQ_ID_W + 1)'(NUM_REQ);
        end
        idx = sum[REQ_ID_W-1:0];
        if (!found && req_valid_i[idx]) begin
          found = 1'b1;
          pick  = idx;
        end
      end
    end
  end

  always_comb begin
    gnt_valid_o  = en_i && found;
    gnt_idx_o    = gnt_valid_o ? pick : '0;
    gnt_onehot_o = gnt_valid_o ? (NUM_REQ'(1) << pick) : '0;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    holder_d    = holder_q;
    burst_cnt_d = burst_cnt_q;
    cnt_next    = keep ? burst_cnt_q + BURST_CNT_W'(1) : BURST_CNT_W'(1);
    if (gnt_valid_o) begin
      if (!keep && holder_active) begin
        rr_ptr_d = wrap_inc(holder_q);
      end
      holder_d = pick;
      if (cnt_next == BURST_CNT_W'(BURST_MAX)) begin
        rr_ptr_d    = wrap_inc(pick);
        burst_cnt_d = '0;
      end else begin
        burst_cnt_d = cnt_next;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      holder_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      holder_q    <= holder_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/fifo_2c_push_sched.sv
// Source-domain push scheduler and clear sequencer for a dual-clock FIFO.
// Optional stall counter output enabled by FIFO_PUSH_SCHED_STATS_EN.
module fifo_2c_push_sched
  import fifo_2c_push_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned REQ_ID_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     busy,
  input  logic                     fifo_full_s,
  input  logic                     fifo_clr_in_prog_s,
  input  logic                     fifo_clr_cmplt_s,
  input  logic                     fifo_error_s,
  output logic                     fifo_push_s_n,
  output logic [WIDTH-1:0]         fifo_data_s,
  output logic                     fifo_clr_s,
  output logic [REQ_ID_W-1:0]      grant_id,
  output logic                     err_sticky
`ifdef FIFO_PUSH_SCHED_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0]   stall_cnt
`endif
);

  state_e              state_q, state_d;
  logic                flush_pending_q, flush_pending_d;
  logic                err_sticky_q, err_sticky_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                arb_en, gnt_valid;
  logic [NUM_REQ-1:0]  gnt_onehot;
  logic [REQ_ID_W-1:0] gnt_idx;
  logic [WIDTH-1:0]    gnt_data;

  // rst_n gates the grant so no push leaks out while reset is held.
  assign arb_en = rst_n && (state_q == StRun) && !fifo_full_s && !fifo_clr_in_prog_s;

  rr_arb_burst #(
    .NUM_REQ   (NUM_REQ),
    .BURST_MAX (BURST_MAX),
    .REQ_ID_W  (REQ_ID_W)
  ) u_arb (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (arb_en),
    .req_valid_i  (req_valid),
    .gnt_valid_o  (gnt_valid),
    .gnt_onehot_o (gnt_onehot),
    .gnt_idx_o    (gnt_idx)
  );

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_onehot[i]) begin
        gnt_data = gnt_data | req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    req_ready     = gnt_onehot;
    grant_id      = gnt_idx;
    fifo_push_s_n = !gnt_valid;
    fifo_data_s   = gnt_valid ? gnt_data : data_q;
    data_d        = fifo_data_s;
    fifo_clr_s    = (state_q == StClrAssert);
    flush_done    = (state_q == StClrDone);
    busy          = (state_q != StRun);
    err_sticky    = err_sticky_q;
  end

  // A request seen outside RUN buys exactly one more clear; repeats coalesce.
  always_comb begin
    state_d         = state_q;
    flush_pending_d = flush_pending_q;
    case (state_q)
      StRun: begin
        if (flush_req || flush_pending_q) begin
          state_d = StClrAssert;
        end
      end
      StClrAssert: state_d = StClrWait;
      StClrWait: begin
        if (fifo_clr_cmplt_s) begin
          state_d = StClrDone;
        end
      end
      StClrDone: state_d = StRun;
      default:   state_d = StRun;
    endcase
    if (state_q == StRun) begin
      flush_pending_d = 1'b0;
    end else if (flush_req) begin
      flush_pending_d = 1'b1;
    end
    err_sticky_d = fifo_error_s || (err_sticky_q && (state_q != StClrDone));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StRun;
      flush_pending_q <= 1'b0;
      err_sticky_q    <= 1'b0;
      data_q          <= '0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
      err_sticky_q    <= err_sticky_d;
      data_q          <= data_d;
    end
  end

`ifdef FIFO_PUSH_SCHED_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == StClrDone) begin
      stall_cnt_d = '0;
    end else if ((state_q == StRun) && (|req_valid) && fifo_full_s && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_2c_push_sched.sv
// Self-checking bench for fifo_2c_push_sched: vector table, push scoreboard and
// hand-written clear sequences.
module tb_fifo_2c_push_sched;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 8;
  localparam int BURST_MAX = 4;
  localparam int REQ_ID_W  = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     flush_req;
  logic                     flush_done;
  logic                     busy;
  logic                     fifo_full_s;
  logic                     fifo_clr_in_prog_s;
  logic                     fifo_clr_cmplt_s;
  logic                     fifo_error_s;
  logic                     fifo_push_s_n;
  logic [WIDTH-1:0]         fifo_data_s;
  logic                     fifo_clr_s;
  logic [REQ_ID_W-1:0]      grant_id;
  logic                     err_sticky;
`ifdef FIFO_PUSH_SCHED_STATS_EN
  logic [15:0]              stall_cnt;
`endif

  fifo_2c_push_sched #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .BURST_MAX (BURST_MAX),
    .REQ_ID_W  (REQ_ID_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_data           (req_data),
    .req_ready          (req_ready),
    .flush_req          (flush_req),
    .flush_done         (flush_done),
    .busy               (busy),
    .fifo_full_s        (fifo_full_s),
    .fifo_clr_in_prog_s (fifo_clr_in_prog_s),
    .fifo_clr_cmplt_s   (fifo_clr_cmplt_s),
    .fifo_error_s       (fifo_error_s),
    .fifo_push_s_n      (fifo_push_s_n),
    .fifo_data_s        (fifo_data_s),
    .fifo_clr_s         (fifo_clr_s),
    .grant_id           (grant_id),
    .err_sticky         (err_sticky)
`ifdef FIFO_PUSH_SCHED_STATS_EN
    ,
    .stall_cnt          (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic       full;
    logic       cip;
    logic       exp_push;
    int         exp_id;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] data;
  } sb_t;

  vec_t       vecs[$];
  sb_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_done   = 0;
  logic [7:0] last_data = 8'h00;

  function automatic logic [7:0] req_word(input int i);
    return 8'hA0 + 8'(i * 17);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input int id);
    sb_t e;
    e.id   = id;
    e.data = req_word(id);
    exp_q.push_back(e);
    last_data = e.data;
  endtask

  task automatic add_vec(input logic [3:0] v, input logic f, input logic c, input logic p,
                         input int id);
    vec_t x;
    x.valid = v; x.full = f; x.cip = c; x.exp_push = p; x.exp_id = id;
    vecs.push_back(x);
  endtask

  // Scoreboard side: every push the DUT makes must match the oldest expectation.
  always @(negedge clk) begin : mon
    sb_t e;
    if (rst_n === 1'b1 && flush_done === 1'b1) n_done++;
    if (rst_n === 1'b1 && fifo_push_s_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_push: got id %0d expected no push", grant_id);
      end else begin
        e = exp_q.pop_front();
        check("sb_grant_id", 32'(grant_id), 32'(e.id));
        check("sb_data", 32'(fifo_data_s), 32'(e.data));
        check("sb_ready", 32'(req_ready), 32'(4'b0001 << e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = req_word(i);
    rst_n = 1'b0; req_valid = 4'b1111; flush_req = 1'b0; fifo_full_s = 1'b0;
    fifo_clr_in_prog_s = 1'b0; fifo_clr_cmplt_s = 1'b0; fifo_error_s = 1'b0;

    // Reset with every requester valid.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_push_n", 32'(fifo_push_s_n), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_clr_s", 32'(fifo_clr_s), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_data", 32'(fifo_data_s), 32'd0);
    check("rst_err", 32'(err_sticky), 32'd0);
    tick();
    rst_n = 1'b1;

    // Vector table: bursts, full gating, clear-in-progress gating, holder drop.
    for (int k = 0; k < 17; k++) add_vec(4'b1111, 1'b0, 1'b0, 1'b1, (k / 4) % 4);
    for (int k = 0; k < 5; k++) add_vec(4'b1111, 1'b1, 1'b0, 1'b0, 0);
    add_vec(4'b1111, 1'b0, 1'b0, 1'b1, 0);
    add_vec(4'b1111, 1'b0, 1'b1, 1'b0, 0);
    add_vec(4'b0000, 1'b0, 1'b0, 1'b0, 0);
    add_vec(4'b0100, 1'b0, 1'b0, 1'b1, 2);
    add_vec(4'b0100, 1'b0, 1'b0, 1'b1, 2);
    add_vec(4'b1001, 1'b0, 1'b0, 1'b1, 3);
    for (int k = 0; k < 5; k++) add_vec(4'b0001, 1'b0, 1'b0, 1'b1, 0);
    add_vec(4'b0000, 1'b0, 1'b0, 1'b0, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      req_valid          = vecs[k].valid;
      fifo_full_s        = vecs[k].full;
      fifo_clr_in_prog_s = vecs[k].cip;
      if (vecs[k].exp_push) expect_push(vecs[k].exp_id);
      @(negedge clk);
      check($sformatf("vec%0d_push_n", k), 32'(fifo_push_s_n), 32'(!vecs[k].exp_push));
      check($sformatf("vec%0d_data", k), 32'(fifo_data_s), 32'(last_data));
      if (!vecs[k].exp_push) check($sformatf("vec%0d_ready", k), 32'(req_ready), 32'd0);
      tick();
    end
`ifdef FIFO_PUSH_SCHED_STATS_EN
    check("stall_cnt", 32'(stall_cnt), 32'd5);
`endif

    // Flush requested on a push cycle.
    rst_n = 1'b0; req_valid = 4'b0000; tick(); rst_n = 1'b1;
    req_valid = 4'b1111; flush_req = 1'b1; expect_push(0);
    @(negedge clk); check("fl_busy0", 32'(busy), 32'd0);
    tick(); flush_req = 1'b0;
    @(negedge clk);
    check("fl_clr_s", 32'(fifo_clr_s), 32'd1);
    check("fl_busy1", 32'(busy), 32'd1);
    check("fl_nopush1", 32'(fifo_push_s_n), 32'd1);
    tick();
    @(negedge clk);
    check("fl_clr_s_once", 32'(fifo_clr_s), 32'd0);
    check("fl_nopush2", 32'(fifo_push_s_n), 32'd1);
    tick(); fifo_clr_cmplt_s = 1'b1;
    @(negedge clk);
    check("fl_done_early", 32'(flush_done), 32'd0);
    check("fl_busy_wait", 32'(busy), 32'd1);
    tick(); fifo_clr_cmplt_s = 1'b0;
    @(negedge clk);
    check("fl_done", 32'(flush_done), 32'd1);
    check("fl_nopush3", 32'(fifo_push_s_n), 32'd1);
    tick(); expect_push(0);
    @(negedge clk);
    check("fl_busy_end", 32'(busy), 32'd0);
    check("fl_done_pulse", 32'(flush_done), 32'd0);
    tick(); req_valid = 4'b0000;

    // Error latch and a coalesced second clear.
    fifo_error_s = 1'b1;
    @(negedge clk); check("err_reg", 32'(err_sticky), 32'd0);
    tick(); fifo_error_s = 1'b0;
    @(negedge clk); check("err_set", 32'(err_sticky), 32'd1);
    tick();
    @(negedge clk); check("err_hold", 32'(err_sticky), 32'd1);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    @(negedge clk); check("p_clr1", 32'(fifo_clr_s), 32'd1);
    tick(); flush_req = 1'b1;
    @(negedge clk); check("p_busy_wait", 32'(busy), 32'd1);
    tick(); flush_req = 1'b1; fifo_clr_cmplt_s = 1'b1;
    tick(); flush_req = 1'b0; fifo_clr_cmplt_s = 1'b0;
    @(negedge clk);
    check("p_done1", 32'(flush_done), 32'd1);
    check("p_err_in_done", 32'(err_sticky), 32'd1);
    tick();
    @(negedge clk);
    check("p_err_clr", 32'(err_sticky), 32'd0);
    check("p_run_busy", 32'(busy), 32'd0);
    tick();
    @(negedge clk); check("p_clr2", 32'(fifo_clr_s), 32'd1);
    tick(); fifo_clr_cmplt_s = 1'b1;
    tick(); fifo_clr_cmplt_s = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      @(negedge clk);
      if (flush_done === 1'b1) found = 1'b1;
      tick();
    end
    check("p_done2_seen", 32'(found), 32'd1);
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      check($sformatf("p_no_third_clr%0d", w), 32'({fifo_clr_s, busy}), 32'd0);
      tick();
    end

    // Reset in the middle of a clear abandons it.
    flush_req = 1'b1; tick(); flush_req = 1'b0; tick();
    rst_n = 1'b0; tick();
    @(negedge clk); check("mid_rst_busy", 32'(busy), 32'd0);
    tick(); rst_n = 1'b1; fifo_clr_cmplt_s = 1'b1;
    @(negedge clk);
    check("mid_rst_no_done", 32'(flush_done), 32'd0);
    check("mid_rst_idle", 32'(busy), 32'd0);
    tick(); fifo_clr_cmplt_s = 1'b0;
    tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("flush_done_count", 32'(n_done), 32'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
